// File: rtl/gen_reg_file_pkg.sv
// Shared constants for the general-purpose register file: defaults and clear-FSM encoding.
package gen_reg_file_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_NUM_REGS = 4;
    localparam int unsigned DEF_NUM_RD   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/gen_reg_file_rdport.sv
// Single registered read port with same-cycle write bypass.
module gen_reg_file_rdport
    import gen_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [SEL_W-1:0]           sel,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic                       clr_act,
    input  logic [SEL_W-1:0]           clr_idx,
    input  logic                       w0_act,
    input  logic [SEL_W-1:0]           w0_sel,
    input  logic [DATA_W-1:0]          w0_data,
    input  logic                       w1_act,
    input  logic [SEL_W-1:0]           w1_sel,
    input  logic [DATA_W-1:0]          w1_data,
    output logic [DATA_W-1:0]          data
);

    logic [DATA_W-1:0] byp;

    // Value the selected register holds after this edge; zero when disabled or out of range.
    always_comb begin
        byp = '0;
        if (en && ({1'b0, sel} < (SEL_W+1)'(NUM_REGS))) begin
            if (clr_act && (sel == clr_idx)) begin
                byp = '0;
            end else if (w0_act && (sel == w0_sel)) begin
                byp = w0_data;
            end else if (w1_act && (sel == w1_sel)) begin
                byp = w1_data;
            end else begin
                byp = regs_flat[sel*DATA_W +: DATA_W];
            end
        end
    end

    // Output register gives the one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= byp;
        end
    end

endmodule

// File: rtl/gen_reg_file.sv
// Register file with two prioritised write ports, NUM_RD bypassed read ports and a sequential clear.
module gen_reg_file
    import gen_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*SEL_W-1:0]    rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr0_en,
    input  logic [SEL_W-1:0]           wr0_sel,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [SEL_W-1:0]           wr1_sel,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       wr_drop,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [SEL_W-1:0]  clr_idx;
    logic [SEL_W-1:0]  clr_idx_nxt;
    logic              clearing;
    logic              w0_in;
    logic              w1_in;
    logic              collide;
    logic              w0_act;
    logic              w1_act;
    logic              drop_nxt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Write qualification: range check, clear lockout and same-index priority.
    always_comb begin
        clearing = (state == ST_CLEAR);
        w0_in    = wr0_en && ({1'b0, wr0_sel} < (SEL_W+1)'(NUM_REGS));
        w1_in    = wr1_en && ({1'b0, wr1_sel} < (SEL_W+1)'(NUM_REGS));
        collide  = w0_in && w1_in && (wr0_sel == wr1_sel);
        w0_act   = w0_in && !clearing;
        w1_act   = w1_in && !clearing && !collide;
        drop_nxt = clearing ? (w0_in || w1_in) : collide;
    end

    // Clear FSM next-state and index sequencing.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx == SEL_W'(NUM_REGS - 1)) begin
                    state_nxt   = ST_IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_idx_nxt = '0;
            end
        endcase
    end

    // FSM state, busy flag and drop pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            clr_busy <= (state_nxt == ST_CLEAR);
            wr_drop  <= drop_nxt;
        end
    end

    // Register storage; wr0 is applied last so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (clearing) begin
            regs[clr_idx] <= '0;
        end else begin
            if (w1_act) begin
                regs[wr1_sel] <= wr1_data;
            end
            if (w0_act) begin
                regs[wr0_sel] <= wr0_data;
            end
        end
    end

    // Flatten stored contents for observation.
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        gen_reg_file_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS)
        ) u_rd (
            .clk       (clk),
            .reset     (reset),
            .en        (rd_en[p]),
            .sel       (rd_sel[p*SEL_W +: SEL_W]),
            .regs_flat (regs_flat),
            .clr_act   (clearing),
            .clr_idx   (clr_idx),
            .w0_act    (w0_act),
            .w0_sel    (wr0_sel),
            .w0_data   (wr0_data),
            .w1_act    (w1_act),
            .w1_sel    (wr1_sel),
            .w1_data   (wr1_data),
            .data      (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule
